calib_seq_ctrl: RTL and testbench
=================================

Name: calib_seq_ctrl

Overview:
Sequencer for the HS alternate-calibration burst on one D-PHY TX lane. On request it drives a burst onto the lane byte interface in this order: a fixed preamble, one sync byte, then a programmed number of PRBS-9 bytes. It steps the PRBS-9 generator through Prbs_Enable, one step per byte the lane accepts. It sits between the calibration/PPI control logic and the lane serializer, alongside the PRBS-9 generator.

Parameters:
PREAMBLE_LEN, 16, number of preamble bytes sent per burst (1..255)
PREAMBLE_BYTE, 8'hFF, value of each preamble byte
SYNC_BYTE, 8'hB8, single sync byte sent after the preamble
LEN_W, 16, width of the burst length input and of the byte counter

Ports:
Clk  in  1  byte clock
TxRst  in  1  synchronous active-high reset
Calib_Req  in  1  level request to start a burst; sampled only in IDLE
Calib_Len  in  LEN_W  number of PRBS bytes to send; latched when the request is accepted
Calib_Abort  in  1  terminate the burst immediately
TxReadyHS  in  1  lane accepts the current byte this cycle
Prbs_Pattern  in  8  current PRBS-9 byte from the generator
Prbs_Enable  out  1  advance the PRBS generator
TxRequestHS  out  1  HS burst request to the lane
TxDataHS  out  8  byte presented to the lane
Calib_Busy  out  1  burst in progress
Calib_Done  out  1  one-cycle pulse on normal completion
Calib_Aborted  out  1  one-cycle pulse when a burst is aborted
Byte_Cnt  out  LEN_W  PRBS bytes accepted in the current or last burst

Behaviour:
- Reset is synchronous: on the Clk edge with TxRst=1, the state goes to IDLE and every output is 0, including Byte_Cnt and TxDataHS.
- State IDLE:
  - Calib_Req=1 and Calib_Abort=0: latch Calib_Len, clear Byte_Cnt, go to PREAMBLE.
  - Calib_Req=1 and Calib_Abort=1 in the same cycle: abort wins; stay in IDLE with no pulse.
- Active states are PREAMBLE, SYNC and PRBS:
  - TxRequestHS=1 and Calib_Busy=1.
  - A byte is "accepted" on any cycle where the state is active and TxReadyHS=1.
  - TxDataHS holds its value while TxReadyHS=0.
- State PREAMBLE:
  - TxDataHS=PREAMBLE_BYTE.
  - An internal counter counts accepted bytes. After PREAMBLE_LEN bytes are accepted, go to SYNC.
- State SYNC:
  - TxDataHS=SYNC_BYTE.
  - On acceptance: if the latched length is 0, go to DONE; otherwise go to PRBS.
- State PRBS:
  - TxDataHS=Prbs_Pattern (combinational pass-through).
  - Prbs_Enable = TxReadyHS in this state only, so the generator advances exactly once per accepted PRBS byte and never outside PRBS.
  - Byte_Cnt increments per accepted byte. When the accepted byte makes Byte_Cnt equal the latched length, go to DONE.
- State DONE (one cycle):
  - TxRequestHS=0, Calib_Busy=0, Calib_Done=1.
  - Go to IDLE next cycle; Calib_Req is ignored in DONE.
  - If Calib_Req is still high in IDLE, a new burst starts. The PRBS sequence continues from where it stopped; it is not reseeded.
- Calib_Abort in any active state:
  - Next cycle the state is IDLE, TxRequestHS=0, Calib_Aborted=1 for one cycle, and Calib_Done stays 0.
  - Prbs_Enable is 0 in the abort cycle.
  - Byte_Cnt keeps its value.
- Length wrap: the maximum length is 2^LEN_W-1. Byte_Cnt never wraps within a burst.
- Latency: from Calib_Req sampled high in IDLE to TxRequestHS=1 is 1 cycle. With TxReadyHS held at 1, the burst lasts PREAMBLE_LEN+1+Calib_Len cycles, followed by the DONE cycle.
- Calib_Len changing mid-burst has no effect.
- A TxRst pulse mid-burst returns the block to IDLE with all outputs 0 on the same edge.

Test Plan:
1. Reset, then Req with Len=4 and TxReadyHS=1 constantly -> 16 cycles of FF, 1 cycle of B8, then 4 PRBS bytes equal to the generator's successive outputs; Prbs_Enable high for exactly 4 cycles; Done pulses once; Byte_Cnt=4.
2. Len=0 -> preamble and sync only; Prbs_Enable never asserted; Done follows the B8 byte.
3. TxReadyHS toggled 1/0 every cycle, Len=3 -> TxDataHS stable during stalls; 3 PRBS steps total; burst takes twice as many cycles.
4. Abort asserted on the 2nd PRBS byte -> Aborted pulse next cycle, TxRequestHS=0, Byte_Cnt=1, no Done; simultaneous Req+Abort in IDLE -> no start.
5. Req held high across Done -> a second burst starts; its first PRBS byte continues the sequence (no reseed).
6. TxRst asserted mid-preamble -> outputs 0 on the next edge; a fresh Req restarts the preamble count from 0.

Source files
------------

// File: rtl/calib_seq_ctrl.sv
// HS alternate-calibration burst sequencer for one D-PHY TX lane:
// preamble bytes, one sync byte, then a programmed count of PRBS-9 bytes.
module calib_seq_ctrl #(
    parameter int          PREAMBLE_LEN  = 16,
    parameter logic [7:0]  PREAMBLE_BYTE = 8'hFF,
    parameter logic [7:0]  SYNC_BYTE     = 8'hB8,
    parameter int          LEN_W         = 16
) (
    input  logic             Clk,
    input  logic             TxRst,
    input  logic             Calib_Req,
    input  logic [LEN_W-1:0] Calib_Len,
    input  logic             Calib_Abort,
    input  logic             TxReadyHS,
    input  logic [7:0]       Prbs_Pattern,
    output logic             Prbs_Enable,
    output logic             TxRequestHS,
    output logic [7:0]       TxDataHS,
    output logic             Calib_Busy,
    output logic             Calib_Done,
    output logic             Calib_Aborted,
    output logic [LEN_W-1:0] Byte_Cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SYNC,
        S_PRBS,
        S_DONE
    } state_t;

    localparam logic [7:0]       PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [LEN_W-1:0] ONE      = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [7:0]       pre_cnt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] byte_cnt;
    logic [LEN_W-1:0] byte_cnt_inc;
    logic             aborted_q;
    logic             active;
    logic             accept;
    logic             start;

    // Abort takes priority over acceptance, so the byte on the abort cycle is never counted.
    always_comb begin
        active       = (state == S_PREAMBLE) || (state == S_SYNC) || (state == S_PRBS);
        accept       = active && TxReadyHS && !Calib_Abort;
        start        = (state == S_IDLE) && Calib_Req && !Calib_Abort;
        byte_cnt_inc = byte_cnt + ONE;
        state_nxt    = state;
        TxDataHS     = 8'h00;
        Prbs_Enable  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_PREAMBLE;
            end
            S_PREAMBLE: begin
                TxDataHS = PREAMBLE_BYTE;
                if (accept && pre_cnt == PRE_LAST) state_nxt = S_SYNC;
            end
            S_SYNC: begin
                TxDataHS = SYNC_BYTE;
                if (accept) state_nxt = (len_q == '0) ? S_DONE : S_PRBS;
            end
            S_PRBS: begin
                TxDataHS    = Prbs_Pattern;
                Prbs_Enable = accept;
                if (accept && byte_cnt_inc == len_q) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (active && Calib_Abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge Clk) begin
        if (TxRst) begin
            state     <= S_IDLE;
            pre_cnt   <= 8'h00;
            len_q     <= '0;
            byte_cnt  <= '0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            aborted_q <= active && Calib_Abort;
            if (start) begin
                len_q    <= Calib_Len;
                byte_cnt <= '0;
                pre_cnt  <= 8'h00;
            end
            if (accept && state == S_PREAMBLE) pre_cnt <= pre_cnt + 8'h01;
            if (accept && state == S_PRBS) byte_cnt <= byte_cnt_inc;
        end
    end

    assign TxRequestHS   = active;
    assign Calib_Busy    = active;
    assign Calib_Done    = (state == S_DONE);
    assign Calib_Aborted = aborted_q;
    assign Byte_Cnt      = byte_cnt;

endmodule

// File: tb/tb_calib_seq_ctrl.sv
// Directed bench for calib_seq_ctrl with a PRBS-9 byte generator stub on the side.
module tb_calib_seq_ctrl;

    localparam int LEN_W  = 16;
    localparam int PRE_N  = 16;

    logic             Clk = 1'b0;
    logic             TxRst;
    logic             Calib_Req;
    logic [LEN_W-1:0] Calib_Len;
    logic             Calib_Abort;
    logic             TxReadyHS;
    logic [7:0]       Prbs_Pattern;
    logic             Prbs_Enable;
    logic             TxRequestHS;
    logic [7:0]       TxDataHS;
    logic             Calib_Busy;
    logic             Calib_Done;
    logic             Calib_Aborted;
    logic [LEN_W-1:0] Byte_Cnt;

    int vecs = 0;
    int errs = 0;

    logic [8:0] gen_lfsr = 9'h1FF;
    logic [8:0] exp_lfsr = 9'h1FF;

    calib_seq_ctrl #(
        .PREAMBLE_LEN (PRE_N),
        .PREAMBLE_BYTE(8'hFF),
        .SYNC_BYTE    (8'hB8),
        .LEN_W        (LEN_W)
    ) dut (
        .Clk          (Clk),
        .TxRst        (TxRst),
        .Calib_Req    (Calib_Req),
        .Calib_Len    (Calib_Len),
        .Calib_Abort  (Calib_Abort),
        .TxReadyHS    (TxReadyHS),
        .Prbs_Pattern (Prbs_Pattern),
        .Prbs_Enable  (Prbs_Enable),
        .TxRequestHS  (TxRequestHS),
        .TxDataHS     (TxDataHS),
        .Calib_Busy   (Calib_Busy),
        .Calib_Done   (Calib_Done),
        .Calib_Aborted(Calib_Aborted),
        .Byte_Cnt     (Byte_Cnt)
    );

    always #5 Clk = ~Clk;

    function automatic logic [8:0] prbs_next(input logic [8:0] s);
        logic [8:0] r;
        r = s;
        for (int i = 0; i < 8; i++) r = {r[7:0], r[8] ^ r[4]};
        return r;
    endfunction

    // Generator stub: advances only when the sequencer asks, never reseeded.
    always @(posedge Clk) if (Prbs_Enable) gen_lfsr <= prbs_next(gen_lfsr);
    assign Prbs_Pattern = gen_lfsr[7:0];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        TxRst = 1'b1; Calib_Req = 1'b1; Calib_Abort = 1'b0; TxReadyHS = 1'b1; Calib_Len = 16'd4;
        tick(); tick();
        vecs++;
        if (TxRequestHS !== 1'b0 || TxDataHS !== 8'h00 || Calib_Busy !== 1'b0 || Calib_Done !== 1'b0 ||
            Calib_Aborted !== 1'b0 || Byte_Cnt !== 16'h0 || Prbs_Enable !== 1'b0)
            begin errs++; $display("FAIL reset: req=%b data=%h busy=%b done=%b abt=%b cnt=%0d en=%b, want all 0",
                TxRequestHS, TxDataHS, Calib_Busy, Calib_Done, Calib_Aborted, Byte_Cnt, Prbs_Enable); end
        Calib_Req = 1'b0; TxRst = 1'b0;
        tick();
        vecs++;
        if (TxRequestHS !== 1'b0 || Calib_Busy !== 1'b0)
            begin errs++; $display("FAIL idle_after_reset: req=%b busy=%b want 0 0", TxRequestHS, Calib_Busy); end
    endtask

    // Runs one burst from IDLE to the cycle after DONE, checking every byte against the model.
    task automatic run_burst(input int len, input bit toggle, input bit hold);
        int k, n, en_cnt, cyc, phase, want_cyc;
        logic rdy;
        logic [7:0] exp_d;
        TxReadyHS = 1'b1; Calib_Len = 16'(len); Calib_Req = 1'b1;
        tick();
        if (!hold) Calib_Req = 1'b0;
        vecs++;
        if (TxRequestHS !== 1'b1 || Byte_Cnt !== 16'h0 || Calib_Busy !== 1'b1)
            begin errs++; $display("FAIL start: req=%b busy=%b cnt=%0d want 1 1 0", TxRequestHS, Calib_Busy, Byte_Cnt); end
        Calib_Len = 16'hFFFF;
        k = 0; n = 0; en_cnt = 0; phase = 0; cyc = 0;
        for (cyc = 0; cyc < 400 && phase != 3; cyc++) begin
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            TxReadyHS = rdy;
            #1;
            case (phase)
                0:       exp_d = 8'hFF;
                1:       exp_d = 8'hB8;
                default: exp_d = exp_lfsr[7:0];
            endcase
            vecs++;
            if (TxDataHS !== exp_d || TxRequestHS !== 1'b1 || Prbs_Enable !== (phase == 2 && rdy))
                begin errs++; $display("FAIL byte len=%0d cyc=%0d: data=%h req=%b en=%b, want %h 1 %b",
                    len, cyc, TxDataHS, TxRequestHS, Prbs_Enable, exp_d, (phase == 2 && rdy)); end
            if (Prbs_Enable) en_cnt++;
            if (rdy) begin
                case (phase)
                    0: begin k++; if (k == PRE_N) phase = 1; end
                    1: phase = (len == 0) ? 3 : 2;
                    default: begin exp_lfsr = prbs_next(exp_lfsr); n++; if (n == len) phase = 3; end
                endcase
            end
            tick();
        end
        TxReadyHS = 1'b1;
        want_cyc = toggle ? 2 * (PRE_N + 1 + len) - 1 : PRE_N + 1 + len;
        vecs++;
        if (phase != 3 || cyc != want_cyc)
            begin errs++; $display("FAIL burst_len len=%0d: cycles=%0d phase=%0d, want %0d cycles", len, cyc, phase, want_cyc); end
        vecs++;
        if (Calib_Done !== 1'b1 || TxRequestHS !== 1'b0 || Calib_Busy !== 1'b0 || Byte_Cnt !== 16'(len) || en_cnt != len)
            begin errs++; $display("FAIL done len=%0d: done=%b req=%b busy=%b cnt=%0d steps=%0d, want 1 0 0 %0d %0d",
                len, Calib_Done, TxRequestHS, Calib_Busy, Byte_Cnt, en_cnt, len, len); end
        tick();
        vecs++;
        if (Calib_Done !== 1'b0 || TxRequestHS !== 1'b0 || Calib_Aborted !== 1'b0)
            begin errs++; $display("FAIL after_done: done=%b req=%b abt=%b want 0 0 0", Calib_Done, TxRequestHS, Calib_Aborted); end
    endtask

    task automatic test_basic();     run_burst(4, 1'b0, 1'b0); endtask
    task automatic test_zero_len();  run_burst(0, 1'b0, 1'b0); endtask
    task automatic test_stall();     run_burst(3, 1'b1, 1'b0); endtask

    task automatic test_abort();
        Calib_Len = 16'd5; Calib_Req = 1'b1; TxReadyHS = 1'b1;
        tick();
        Calib_Req = 1'b0;
        repeat (PRE_N + 1) tick();
        vecs++;
        if (TxDataHS !== exp_lfsr[7:0] || Prbs_Enable !== 1'b1)
            begin errs++; $display("FAIL abort_byte1: data=%h en=%b want %h 1", TxDataHS, Prbs_Enable, exp_lfsr[7:0]); end
        exp_lfsr = prbs_next(exp_lfsr);
        tick();
        Calib_Abort = 1'b1;
        #1;
        vecs++;
        if (TxDataHS !== exp_lfsr[7:0] || Prbs_Enable !== 1'b0)
            begin errs++; $display("FAIL abort_cycle: data=%h en=%b want %h 0", TxDataHS, Prbs_Enable, exp_lfsr[7:0]); end
        tick();
        vecs++;
        if (Calib_Aborted !== 1'b1 || TxRequestHS !== 1'b0 || Calib_Done !== 1'b0 || Byte_Cnt !== 16'd1 || Calib_Busy !== 1'b0)
            begin errs++; $display("FAIL aborted: abt=%b req=%b done=%b cnt=%0d busy=%b want 1 0 0 1 0",
                Calib_Aborted, TxRequestHS, Calib_Done, Byte_Cnt, Calib_Busy); end
        Calib_Abort = 1'b0;
        tick();
        vecs++;
        if (Calib_Aborted !== 1'b0 || Calib_Done !== 1'b0 || Byte_Cnt !== 16'd1)
            begin errs++; $display("FAIL abort_pulse: abt=%b done=%b cnt=%0d want 0 0 1", Calib_Aborted, Calib_Done, Byte_Cnt); end
        Calib_Req = 1'b1; Calib_Abort = 1'b1;
        tick();
        vecs++;
        if (TxRequestHS !== 1'b0 || Calib_Aborted !== 1'b0 || Calib_Busy !== 1'b0)
            begin errs++; $display("FAIL req_abort_idle: req=%b abt=%b busy=%b want 0 0 0", TxRequestHS, Calib_Aborted, Calib_Busy); end
        Calib_Req = 1'b0; Calib_Abort = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        run_burst(2, 1'b0, 1'b1);
        run_burst(2, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        Calib_Len = 16'd3; Calib_Req = 1'b1; TxReadyHS = 1'b1;
        tick();
        Calib_Req = 1'b0;
        repeat (5) tick();
        TxRst = 1'b1;
        tick();
        vecs++;
        if (TxRequestHS !== 1'b0 || TxDataHS !== 8'h00 || Calib_Busy !== 1'b0 || Calib_Done !== 1'b0 ||
            Calib_Aborted !== 1'b0 || Byte_Cnt !== 16'h0 || Prbs_Enable !== 1'b0)
            begin errs++; $display("FAIL reset_mid: req=%b data=%h busy=%b done=%b abt=%b cnt=%0d en=%b, want all 0",
                TxRequestHS, TxDataHS, Calib_Busy, Calib_Done, Calib_Aborted, Byte_Cnt, Prbs_Enable); end
        TxRst = 1'b0;
        tick();
        run_burst(1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_stall();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
